output_safety_gate: RTL and testbench
=====================================

# output_safety_gate

Parametrised successor to the board-level output disable logic. It gates a bus of NUM_IOS actuator outputs (motor PWM/direction, UART TX, LEDs) between the processor-driven values and a per-bit safe default. Outputs are forced to the safe default whenever any of NUM_IN debounced shutdown sources asserts or the software heartbeat watchdog expires. After a trip the gate latches the cause and re-enables only on an explicit re-arm followed by a clean hold-off period. It sits between the SOPC GPIO outputs and the top-level pins.

## Interface

- NUM_IN, 3: number of shutdown sources (keys, kill switch, ...)
- NUM_IOS, 51: gated output width
- DEBOUNCE, 16: consecutive stable samples required to change a filtered source (≥1)
- HOLDOFF, 50000: clean cycles required before re-enabling (≥1)
- WDT_CYCLES, 5000000: heartbeat timeout in cycles; 0 disables the watchdog

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- shutdown  in  NUM_IN  active-high shutdown requests, asynchronous to clk
- shutdown_mask  in  NUM_IN  1 = ignore that source (quasi-static)
- heartbeat  in  1  single-cycle kick from software
- rearm  in  1  single-cycle re-arm request
- gpio_in  in  NUM_IOS  functional output values
- gpio_out_default  in  NUM_IOS  safe values (quasi-static)
- gpio_out  out  NUM_IOS  gated pins
- gate_state  out  2  HOLDOFF=0, RUN=1, TRIPPED=2
- cause  out  NUM_IN+1  sticky trip cause; bit NUM_IN = watchdog
- enabled  out  1  high only in RUN

## Operation

- Each shutdown bit passes a 2-flop synchroniser, then a symmetric debounce counter. The filtered bit changes only after DEBOUNCE consecutive synchronised samples at the new level. The counter clears on any mismatch.
- active = filtered & ~shutdown_mask.
- FSM:
  - Reset enters HOLDOFF with the hold counter at 0.
  - HOLDOFF: the hold counter increments while active==0 and clears to 0 on any active bit. When the counter reaches HOLDOFF-1 with active==0, go to RUN.
  - HOLDOFF: any active bit goes to TRIPPED and ORs active into cause.
  - RUN: any active bit, or watchdog expiry, goes to TRIPPED. active bits are ORed into cause, and cause[NUM_IN] is set on expiry.
  - TRIPPED: rearm with active==0 goes to HOLDOFF, clears cause and clears the hold counter.
  - TRIPPED: rearm while any bit is active is ignored. The request is not remembered.
- Watchdog: the counter runs only in RUN. It resets to 0 on heartbeat and on entry to RUN. Expiry is count==WDT_CYCLES-1 without a heartbeat in that cycle; a heartbeat in the same cycle wins.
- Simultaneous trip and rearm: the trip wins (state stays or becomes TRIPPED, cause updated).
- Output path:
  - gpio_in is registered to gpio_in_q.
  - gpio_out = en_q ? gpio_in_q : gpio_out_default, evaluated per bit.
  - en_q is a flop loaded with (next_state==RUN).

## Timing

- Reset values: en_q=0, so gpio_out=gpio_out_default immediately and asynchronously. gate_state=HOLDOFF, cause=0, enabled=0, all counters 0, gpio_in_q=0.
- Functional latency: gpio_in to gpio_out is 1 cycle in RUN.
- Shutdown latency: a clean rising edge on shutdown forces gpio_out to default DEBOUNCE+3 cycles after the first sampling edge. Sync takes 2 cycles, the filter DEBOUNCE, and the state/en_q flop 1.
- Watchdog trip: gpio_out is at default on the cycle after the expiry cycle.
- Power-up: RUN is reached HOLDOFF cycles after reset release, provided shutdowns are clean.
- Reset mid-trip: cause is lost and the block restarts in HOLDOFF. This is intended.

## Structure

- Package output_safety_pkg holds:
  - the gate_state encodings (HOLDOFF/RUN/TRIPPED, 2 bits)
  - the cause bit index of the watchdog (relative to NUM_IN)
- Counter widths are derived with $clog2 of DEBOUNCE, HOLDOFF and WDT_CYCLES, each with a minimum width of 1.
- Sub-module debounce_filter (parameter DEBOUNCE; ports clk, reset_n, d, q) contains the synchroniser and counter. It is instantiated NUM_IN times by generate.
- The FSM, watchdog and output mux live in the top module.

## Test plan

Bench parameters: NUM_IN=3, NUM_IOS=8, DEBOUNCE=4, HOLDOFF=10, WDT_CYCLES=20. Drive gpio_in=8'hA5 and gpio_out_default=8'h20.

- Reset release, no shutdowns, heartbeat every 10 cycles -> gpio_out=8'h20 until cycle 10; state RUN; then gpio_out tracks gpio_in with 1-cycle lag.
- shutdown[1] glitch of 3 cycles -> no trip. A held assertion -> gpio_out=8'h20 exactly 7 cycles later, cause=4'b0010, state TRIPPED.
- Stop heartbeats in RUN -> trip after 20 cycles, cause=4'b1000. A heartbeat landing on the expiry cycle -> no trip.
- rearm while shutdown[1] is still asserted -> ignored. Deassert, wait for the filter, then rearm -> cause=0, HOLDOFF, RUN after 10 cycles. Reasserting during HOLDOFF -> back to TRIPPED.
- shutdown_mask=3'b001 with shutdown[0] held -> no trip. rearm and shutdown[2] in the same cycle -> remain TRIPPED.
- Assert reset_n low while TRIPPED -> gpio_out=8'h20 asynchronously, cause=0, state HOLDOFF.

Source files
------------

// File: rtl/output_safety_pkg.sv
// Shared definitions for the output safety gate: gate state encodings,
// watchdog cause bit placement and a counter width helper.
package output_safety_pkg;

    // Externally visible gate state; the encoding is part of the register map.
    typedef enum logic [1:0] {
        GATE_HOLDOFF = 2'd0,
        GATE_RUN     = 2'd1,
        GATE_TRIPPED = 2'd2
    } gate_state_t;

    // The watchdog cause bit sits directly above the shutdown source bits.
    localparam int WDT_CAUSE_OFFSET = 0;

    function automatic int wdt_cause_bit(input int num_in);
        return num_in + WDT_CAUSE_OFFSET;
    endfunction

    // Bits needed to count 0..value-1, never less than one bit.
    function automatic int width_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser followed by a symmetric debounce filter. The output
// follows the input only after DEBOUNCE consecutive synchronised samples at
// the new level; any sample matching the current output restarts the count.
module debounce_filter
    import output_safety_pkg::*;
#(
    parameter int DEBOUNCE = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    localparam int CNT_W = width_min1(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             q_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Bring the asynchronous request into the clk domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= d;
            sync2_reg <= sync1_reg;
        end
    end

    // Count consecutive samples that disagree with the filtered level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_reg   <= 1'b0;
            cnt_reg <= '0;
        end else if (sync2_reg == q_reg) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
            q_reg   <= sync2_reg;
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/output_safety_gate.sv
// Gates a bus of actuator outputs between functional values and per-bit safe
// defaults. Debounced shutdown sources or a missed software heartbeat trip the
// gate; it latches the cause and only re-enables after an explicit re-arm
// followed by a clean hold-off period.
module output_safety_gate
    import output_safety_pkg::*;
#(
    parameter int NUM_IN     = 3,
    parameter int NUM_IOS    = 51,
    parameter int DEBOUNCE   = 16,
    parameter int HOLDOFF    = 50000,
    parameter int WDT_CYCLES = 5000000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_IN-1:0]  shutdown,
    input  logic [NUM_IN-1:0]  shutdown_mask,
    input  logic               heartbeat,
    input  logic               rearm,
    input  logic [NUM_IOS-1:0] gpio_in,
    input  logic [NUM_IOS-1:0] gpio_out_default,
    output logic [NUM_IOS-1:0] gpio_out,
    output logic [1:0]         gate_state,
    output logic [NUM_IN:0]    cause,
    output logic               enabled
);

    localparam int HOLD_W  = width_min1(HOLDOFF);
    localparam int WDT_W   = width_min1(WDT_CYCLES);
    localparam int WDT_BIT = wdt_cause_bit(NUM_IN);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);
    localparam logic [WDT_W-1:0]  WDT_LAST  = WDT_W'((WDT_CYCLES > 0) ? WDT_CYCLES - 1 : 0);

    gate_state_t        state_reg, state_next;
    logic [NUM_IN:0]    cause_reg, cause_next;
    logic [HOLD_W-1:0]  hold_reg, hold_next;
    logic [WDT_W-1:0]   wdt_reg, wdt_next;
    logic               en_reg;
    logic [NUM_IOS-1:0] gpio_in_reg;
    logic [NUM_IN-1:0]  filtered;
    logic [NUM_IN-1:0]  active;
    logic               wdt_expire;

    genvar gi;

    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_filter
            debounce_filter #(
                .DEBOUNCE(DEBOUNCE)
            ) u_filter (
                .clk    (clk),
                .reset_n(reset_n),
                .d      (shutdown[gi]),
                .q      (filtered[gi])
            );
        end
    endgenerate

    assign active = filtered & ~shutdown_mask;

    // A heartbeat in the final cycle of the window still counts as a kick.
    assign wdt_expire = (WDT_CYCLES != 0) && (state_reg == GATE_RUN) &&
                        !heartbeat && (wdt_reg == WDT_LAST);

    // Next-state, cause and hold-off counter; a trip always beats a re-arm.
    always_comb begin
        state_next = state_reg;
        cause_next = cause_reg;
        hold_next  = hold_reg;
        case (state_reg)
            GATE_HOLDOFF: begin
                if (|active) begin
                    state_next                 = GATE_TRIPPED;
                    cause_next[NUM_IN-1:0]     = cause_reg[NUM_IN-1:0] | active;
                    hold_next                  = '0;
                end else if (hold_reg == HOLD_LAST) begin
                    state_next = GATE_RUN;
                    hold_next  = '0;
                end else begin
                    hold_next = hold_reg + HOLD_W'(1);
                end
            end
            GATE_RUN: begin
                if ((|active) || wdt_expire) begin
                    state_next             = GATE_TRIPPED;
                    cause_next[NUM_IN-1:0] = cause_reg[NUM_IN-1:0] | active;
                    cause_next[WDT_BIT]    = cause_reg[WDT_BIT] | wdt_expire;
                end
            end
            GATE_TRIPPED: begin
                if (|active) begin
                    cause_next[NUM_IN-1:0] = cause_reg[NUM_IN-1:0] | active;
                end else if (rearm) begin
                    state_next = GATE_HOLDOFF;
                    cause_next = '0;
                    hold_next  = '0;
                end
            end
            default: begin
                state_next = GATE_HOLDOFF;
                hold_next  = '0;
            end
        endcase
    end

    // Watchdog only counts while staying in RUN; anything else restarts it.
    always_comb begin
        wdt_next = '0;
        if ((WDT_CYCLES != 0) && (state_reg == GATE_RUN) &&
            (state_next == GATE_RUN) && !heartbeat) begin
            wdt_next = wdt_reg + WDT_W'(1);
        end
    end

    // Control state registers; en_reg tracks RUN without a decode delay.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= GATE_HOLDOFF;
            cause_reg <= '0;
            hold_reg  <= '0;
            wdt_reg   <= '0;
            en_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cause_reg <= cause_next;
            hold_reg  <= hold_next;
            wdt_reg   <= wdt_next;
            en_reg    <= (state_next == GATE_RUN);
        end
    end

    // Register functional outputs so they align with en_reg.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gpio_in_reg <= '0;
        end else begin
            gpio_in_reg <= gpio_in;
        end
    end

    // Per-bit output select; reset forces the safe defaults immediately.
    generate
        for (gi = 0; gi < NUM_IOS; gi++) begin : g_out_mux
            assign gpio_out[gi] = en_reg ? gpio_in_reg[gi] : gpio_out_default[gi];
        end
    endgenerate

    assign gate_state = state_reg;
    assign cause      = cause_reg;
    assign enabled    = (state_reg == GATE_RUN);

endmodule

// File: tb/tb_output_safety_gate.sv
// Self-checking bench for output_safety_gate with a behavioural reference
// model: sliding-window debounce, clean-cycle and idle-cycle counting.
module tb_output_safety_gate;

    localparam int NUM_IN     = 3;
    localparam int NUM_IOS    = 8;
    localparam int DEBOUNCE   = 4;
    localparam int HOLDOFF    = 10;
    localparam int WDT_CYCLES = 20;
    localparam int M_HOLD = 0;
    localparam int M_RUN  = 1;
    localparam int M_TRIP = 2;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [NUM_IN-1:0]  shutdown = '0;
    logic [NUM_IN-1:0]  shutdown_mask = '0;
    logic               heartbeat = 1'b0;
    logic               rearm = 1'b0;
    logic [NUM_IOS-1:0] gpio_in = 8'hA5;
    logic [NUM_IOS-1:0] gpio_out_default = 8'h20;
    logic [NUM_IOS-1:0] gpio_out;
    logic [1:0]         gate_state;
    logic [NUM_IN:0]    cause;
    logic               enabled;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit hb_auto = 1'b1;

    // Reference model state
    logic [NUM_IN-1:0]  raw_q[$];
    logic [NUM_IN-1:0]  sync_q[$];
    logic [NUM_IN-1:0]  m_filt;
    int                 m_state;
    int                 m_clean;
    int                 m_idle;
    logic [NUM_IN:0]    m_cause;
    logic               m_en;
    logic [NUM_IOS-1:0] m_gq;

    always #5 clk = ~clk;

    output_safety_gate #(
        .NUM_IN(NUM_IN), .NUM_IOS(NUM_IOS), .DEBOUNCE(DEBOUNCE),
        .HOLDOFF(HOLDOFF), .WDT_CYCLES(WDT_CYCLES)
    ) dut (
        .clk(clk), .reset_n(reset_n), .shutdown(shutdown),
        .shutdown_mask(shutdown_mask), .heartbeat(heartbeat), .rearm(rearm),
        .gpio_in(gpio_in), .gpio_out_default(gpio_out_default),
        .gpio_out(gpio_out), .gate_state(gate_state), .cause(cause),
        .enabled(enabled)
    );

    task automatic model_reset();
        raw_q.delete();
        raw_q.push_back('0);
        raw_q.push_back('0);
        sync_q.delete();
        m_filt  = '0;
        m_state = M_HOLD;
        m_clean = 0;
        m_idle  = 0;
        m_cause = '0;
        m_en    = 1'b0;
        m_gq    = '0;
    endtask

    // One clock edge of the specified behaviour, using the inputs seen at it.
    task automatic model_step();
        logic [NUM_IN-1:0] act;
        logic [NUM_IN-1:0] w;
        bit all_set;
        bit all_clr;
        bit wdt_trip;
        act = m_filt & ~shutdown_mask;
        case (m_state)
            M_HOLD: begin
                if (act != 0) begin
                    m_state = M_TRIP;
                    m_cause[NUM_IN-1:0] = m_cause[NUM_IN-1:0] | act;
                end else begin
                    m_clean++;
                    if (m_clean >= HOLDOFF) begin
                        m_state = M_RUN;
                        m_idle  = 0;
                    end
                end
            end
            M_RUN: begin
                if (heartbeat) m_idle = 0;
                else m_idle++;
                wdt_trip = (m_idle >= WDT_CYCLES);
                if (act != 0 || wdt_trip) begin
                    m_state = M_TRIP;
                    m_cause[NUM_IN-1:0] = m_cause[NUM_IN-1:0] | act;
                    if (wdt_trip) m_cause[NUM_IN] = 1'b1;
                end
            end
            default: begin
                if (act != 0) begin
                    m_cause[NUM_IN-1:0] = m_cause[NUM_IN-1:0] | act;
                end else if (rearm) begin
                    m_state = M_HOLD;
                    m_cause = '0;
                    m_clean = 0;
                end
            end
        endcase
        m_en = (m_state == M_RUN);
        m_gq = gpio_in;
        // Synchronised sample is the raw value from two edges earlier.
        raw_q.push_back(shutdown);
        sync_q.push_back(raw_q[0]);
        void'(raw_q.pop_front());
        if (sync_q.size() > DEBOUNCE) void'(sync_q.pop_front());
        if (sync_q.size() == DEBOUNCE) begin
            for (int b = 0; b < NUM_IN; b++) begin
                all_set = 1'b1;
                all_clr = 1'b1;
                for (int k = 0; k < DEBOUNCE; k++) begin
                    w = sync_q[k];
                    if (w[b]) all_clr = 1'b0;
                    else all_set = 1'b0;
                end
                if (all_set) m_filt[b] = 1'b1;
                if (all_clr) m_filt[b] = 1'b0;
            end
        end
    endtask

    function automatic logic [NUM_IOS-1:0] exp_gpio();
        return m_en ? m_gq : gpio_out_default;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_step();
        #1;
        cyc++;
        rearm = 1'b0;
        heartbeat = hb_auto && (cyc % 10 == 0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (gpio_out !== 8'h20) begin
            errors++;
            $display("FAIL reset_gpio got=%h exp=20", gpio_out);
        end
        checks++;
        if ({gate_state, cause, enabled} !== 7'b0) begin
            errors++;
            $display("FAIL reset_state got st=%0d cause=%b en=%b exp st=0 cause=0000 en=0", gate_state, cause, enabled);
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;
        for (int i = 1; i <= HOLDOFF + 5; i++) begin
            tick();
            checks++;
            if ({gpio_out, gate_state, cause, enabled} !== {exp_gpio(), 2'(m_state), m_cause, m_en}) begin
                errors++;
                $display("FAIL powerup_model cyc=%0d got out=%h st=%0d cause=%b en=%b exp out=%h st=%0d cause=%b en=%b", cyc, gpio_out, gate_state, cause, enabled, exp_gpio(), m_state, m_cause, m_en);
            end
            if (i == HOLDOFF - 1) begin
                checks++;
                if (gpio_out !== 8'h20 || gate_state !== 2'd0) begin
                    errors++;
                    $display("FAIL powerup_before_run got out=%h st=%0d exp out=20 st=0", gpio_out, gate_state);
                end
            end
            if (i == HOLDOFF) begin
                checks++;
                if (gpio_out !== 8'hA5 || gate_state !== 2'd1 || enabled !== 1'b1) begin
                    errors++;
                    $display("FAIL powerup_run got out=%h st=%0d en=%b exp out=a5 st=1 en=1", gpio_out, gate_state, enabled);
                end
            end
        end
    endtask

    task automatic test_functional();
        logic [NUM_IOS-1:0] prev;
        for (int i = 0; i < 16; i++) begin
            prev = gpio_in;
            tick();
            checks++;
            if (gpio_out !== prev) begin
                errors++;
                $display("FAIL func_lag cyc=%0d got=%h exp=%h", cyc, gpio_out, prev);
            end
            checks++;
            if ({gpio_out, gate_state, cause, enabled} !== {exp_gpio(), 2'(m_state), m_cause, m_en}) begin
                errors++;
                $display("FAIL func_model cyc=%0d got out=%h st=%0d cause=%b en=%b exp out=%h st=%0d cause=%b en=%b", cyc, gpio_out, gate_state, cause, enabled, exp_gpio(), m_state, m_cause, m_en);
            end
            gpio_in = 8'($urandom);
        end
        gpio_in = 8'hA5;
        tick();
    endtask

    task automatic test_glitch();
        int len;
        for (int g = 0; g < 2; g++) begin
            len = (g == 0) ? 3 : int'($urandom_range(1, 3));
            shutdown[1] = 1'b1;
            for (int i = 0; i < len; i++) tick();
            shutdown[1] = 1'b0;
            for (int i = 0; i < 10; i++) begin
                tick();
                checks++;
                if ({gpio_out, gate_state, cause, enabled} !== {exp_gpio(), 2'(m_state), m_cause, m_en}) begin
                    errors++;
                    $display("FAIL glitch_model cyc=%0d got out=%h st=%0d cause=%b en=%b exp out=%h st=%0d cause=%b en=%b", cyc, gpio_out, gate_state, cause, enabled, exp_gpio(), m_state, m_cause, m_en);
                end
            end
            checks++;
            if (gate_state !== 2'd1 || cause !== 4'b0000) begin
                errors++;
                $display("FAIL glitch_no_trip len=%0d got st=%0d cause=%b exp st=1 cause=0000", len, gate_state, cause);
            end
        end
        shutdown[1] = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            checks++;
            if ({gpio_out, gate_state, cause, enabled} !== {exp_gpio(), 2'(m_state), m_cause, m_en}) begin
                errors++;
                $display("FAIL held_model cyc=%0d got out=%h st=%0d cause=%b en=%b exp out=%h st=%0d cause=%b en=%b", cyc, gpio_out, gate_state, cause, enabled, exp_gpio(), m_state, m_cause, m_en);
            end
            if (i == 6) begin
                checks++;
                if (gpio_out !== 8'hA5 || enabled !== 1'b1) begin
                    errors++;
                    $display("FAIL held_early got out=%h en=%b exp out=a5 en=1", gpio_out, enabled);
                end
            end
            if (i == 7) begin
                checks++;
                if (gpio_out !== 8'h20 || gate_state !== 2'd2 || cause !== 4'b0010) begin
                    errors++;
                    $display("FAIL held_trip got out=%h st=%0d cause=%b exp out=20 st=2 cause=0010", gpio_out, gate_state, cause);
                end
            end
        end
    endtask

    task automatic test_rearm();
        rearm = 1'b1;
        tick();
        checks++;
        if (gate_state !== 2'd2 || cause !== 4'b0010) begin
            errors++;
            $display("FAIL rearm_while_active got st=%0d cause=%b exp st=2 cause=0010", gate_state, cause);
        end
        shutdown[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if ({gpio_out, gate_state, cause, enabled} !== {exp_gpio(), 2'(m_state), m_cause, m_en}) begin
                errors++;
                $display("FAIL rearm_model cyc=%0d got out=%h st=%0d cause=%b en=%b exp out=%h st=%0d cause=%b en=%b", cyc, gpio_out, gate_state, cause, enabled, exp_gpio(), m_state, m_cause, m_en);
            end
        end
        rearm = 1'b1;
        tick();
        checks++;
        if (gate_state !== 2'd0 || cause !== 4'b0000) begin
            errors++;
            $display("FAIL rearm_clean got st=%0d cause=%b exp st=0 cause=0000", gate_state, cause);
        end
        for (int i = 1; i <= HOLDOFF; i++) begin
            tick();
            if (i == HOLDOFF - 1) begin
                checks++;
                if (gate_state !== 2'd0) begin
                    errors++;
                    $display("FAIL rearm_holdoff got st=%0d exp st=0", gate_state);
                end
            end
        end
        checks++;
        if (gate_state !== 2'd1 || enabled !== 1'b1) begin
            errors++;
            $display("FAIL rearm_run got st=%0d en=%b exp st=1 en=1", gate_state, enabled);
        end
    endtask

    task automatic test_watchdog();
        hb_auto = 1'b0;
        heartbeat = 1'b1;
        tick();
        for (int i = 1; i <= WDT_CYCLES; i++) begin
            tick();
            checks++;
            if ({gpio_out, gate_state, cause, enabled} !== {exp_gpio(), 2'(m_state), m_cause, m_en}) begin
                errors++;
                $display("FAIL wdt_model cyc=%0d got out=%h st=%0d cause=%b en=%b exp out=%h st=%0d cause=%b en=%b", cyc, gpio_out, gate_state, cause, enabled, exp_gpio(), m_state, m_cause, m_en);
            end
            if (i == WDT_CYCLES - 1) begin
                checks++;
                if (gate_state !== 2'd1) begin
                    errors++;
                    $display("FAIL wdt_early got st=%0d exp st=1", gate_state);
                end
            end
        end
        checks++;
        if (gate_state !== 2'd2 || cause !== 4'b1000 || gpio_out !== 8'h20) begin
            errors++;
            $display("FAIL wdt_trip got st=%0d cause=%b out=%h exp st=2 cause=1000 out=20", gate_state, cause, gpio_out);
        end
        rearm = 1'b1;
        tick();
        repeat (HOLDOFF) tick();
        repeat (WDT_CYCLES - 1) tick();
        heartbeat = 1'b1;
        tick();
        checks++;
        if (gate_state !== 2'd1 || gate_state !== 2'(m_state)) begin
            errors++;
            $display("FAIL wdt_kick_on_expiry got st=%0d exp st=1", gate_state);
        end
        for (int i = 1; i <= WDT_CYCLES; i++) tick();
        checks++;
        if (gate_state !== 2'd2 || cause !== 4'b1000) begin
            errors++;
            $display("FAIL wdt_trip2 got st=%0d cause=%b exp st=2 cause=1000", gate_state, cause);
        end
        rearm = 1'b1;
        tick();
        repeat (2) tick();
        shutdown[0] = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            checks++;
            if ({gpio_out, gate_state, cause, enabled} !== {exp_gpio(), 2'(m_state), m_cause, m_en}) begin
                errors++;
                $display("FAIL hold_retrip_model cyc=%0d got out=%h st=%0d cause=%b en=%b exp out=%h st=%0d cause=%b en=%b", cyc, gpio_out, gate_state, cause, enabled, exp_gpio(), m_state, m_cause, m_en);
            end
        end
        checks++;
        if (gate_state !== 2'd2 || cause !== 4'b0001) begin
            errors++;
            $display("FAIL hold_retrip got st=%0d cause=%b exp st=2 cause=0001", gate_state, cause);
        end
    endtask

    task automatic test_mask();
        shutdown_mask = 3'b001;
        rearm = 1'b1;
        tick();
        repeat (HOLDOFF) tick();
        hb_auto = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            checks++;
            if ({gpio_out, gate_state, cause, enabled} !== {exp_gpio(), 2'(m_state), m_cause, m_en}) begin
                errors++;
                $display("FAIL mask_model cyc=%0d got out=%h st=%0d cause=%b en=%b exp out=%h st=%0d cause=%b en=%b", cyc, gpio_out, gate_state, cause, enabled, exp_gpio(), m_state, m_cause, m_en);
            end
        end
        checks++;
        if (gate_state !== 2'd1 || enabled !== 1'b1) begin
            errors++;
            $display("FAIL mask_run got st=%0d en=%b exp st=1 en=1", gate_state, enabled);
        end
        hb_auto = 1'b0;
        heartbeat = 1'b0;
        repeat (25) tick();
        checks++;
        if (gate_state !== 2'd2 || cause !== 4'b1000) begin
            errors++;
            $display("FAIL mask_wdt got st=%0d cause=%b exp st=2 cause=1000", gate_state, cause);
        end
        shutdown[2] = 1'b1;
        repeat (DEBOUNCE + 2) tick();
        rearm = 1'b1;
        tick();
        checks++;
        if (gate_state !== 2'd2 || cause !== 4'b1100 || gpio_out !== 8'h20) begin
            errors++;
            $display("FAIL trip_beats_rearm got st=%0d cause=%b out=%h exp st=2 cause=1100 out=20", gate_state, cause, gpio_out);
        end
        checks++;
        if (cause !== m_cause) begin
            errors++;
            $display("FAIL trip_beats_rearm_model got cause=%b exp cause=%b", cause, m_cause);
        end
    endtask

    task automatic test_async_reset();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (gpio_out !== 8'h20 || gate_state !== 2'd0 || cause !== 4'b0000 || enabled !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_tripped got out=%h st=%0d cause=%b en=%b exp out=20 st=0 cause=0000 en=0", gpio_out, gate_state, cause, enabled);
        end
        model_reset();
        shutdown = '0;
        shutdown_mask = '0;
        hb_auto = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;
        repeat (HOLDOFF) tick();
        checks++;
        if (gate_state !== 2'd1 || gpio_out !== 8'hA5) begin
            errors++;
            $display("FAIL restart_run got st=%0d out=%h exp st=1 out=a5", gate_state, gpio_out);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (gpio_out !== 8'h20 || enabled !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_run got out=%h en=%b exp out=20 en=0", gpio_out, enabled);
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            gpio_in = 8'($urandom);
            for (int b = 0; b < NUM_IN; b++) begin
                if ($urandom_range(0, 11) == 0) shutdown[b] = ~shutdown[b];
            end
            if ($urandom_range(0, 149) == 0) shutdown_mask = 3'($urandom);
            if ($urandom_range(0, 15) == 0) rearm = 1'b1;
            heartbeat = ($urandom_range(0, 6) == 0);
            tick();
            checks++;
            if ({gpio_out, gate_state, cause, enabled} !== {exp_gpio(), 2'(m_state), m_cause, m_en}) begin
                errors++;
                $display("FAIL random_model cyc=%0d got out=%h st=%0d cause=%b en=%b exp out=%h st=%0d cause=%b en=%b", cyc, gpio_out, gate_state, cause, enabled, exp_gpio(), m_state, m_cause, m_en);
            end
        end
    endtask

    initial begin
        test_reset();
        test_functional();
        test_glitch();
        test_rearm();
        test_watchdog();
        test_mask();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
